// File: rtl/main_pop_arb_if.sv
// ----------------------------------------------------------------------------
// main_pop_arb_if
//   Bundles the signals between the main FIFO pop arbiter, the main FIFO,
//   the per-VC almost-full flags and the VC demux.
//
//   Parameters
//     DATA_W  width of the main FIFO word / demux word
//     NUM_VC  number of virtual channels (width of VC_almost_full)
//
//   Signals
//     Main_empty          main FIFO empty flag            (to arbiter)
//     Main_data_out       main FIFO show-ahead head word  (to arbiter)
//     VC_almost_full      per-VC almost-full flags        (to arbiter)
//     Main_rd             pop strobe to main FIFO         (from arbiter)
//     demux_vcid_in       registered word to demux        (from arbiter)
//     demux_vcid_valid_in valid for demux_vcid_in         (from arbiter)
//     pop_state           00 IDLE, 01 RUN, 10 HOLD        (from arbiter)
//     hol_blocked         head-of-line starvation flag    (from arbiter)
//     pop_count           popped-word counter             (from arbiter)
//
//   Modports
//     master  the arbiter side
//     slave   the FIFO / demux / monitor side
// ----------------------------------------------------------------------------
interface main_pop_arb_if #(
  parameter int DATA_W = 6,
  parameter int NUM_VC = 2
);
  logic              Main_empty;
  logic [DATA_W-1:0] Main_data_out;
  logic [NUM_VC-1:0] VC_almost_full;
  logic              Main_rd;
  logic [DATA_W-1:0] demux_vcid_in;
  logic              demux_vcid_valid_in;
  logic [1:0]        pop_state;
  logic              hol_blocked;
  logic [15:0]       pop_count;

  modport master (
    input  Main_empty, Main_data_out, VC_almost_full,
    output Main_rd, demux_vcid_in, demux_vcid_valid_in,
           pop_state, hol_blocked, pop_count
  );

  modport slave (
    output Main_empty, Main_data_out, VC_almost_full,
    input  Main_rd, demux_vcid_in, demux_vcid_valid_in,
           pop_state, hol_blocked, pop_count
  );
endinterface

// File: rtl/main_pop_arb.sv
// ----------------------------------------------------------------------------
// main_pop_arb
//   Pops words from a show-ahead main FIFO and forwards them, one cycle
//   later, to the VC demux. A word is popped only when its destination VC
//   (or, in STRICT mode, every VC) has room. Tracks head-of-line blocking
//   and, optionally, the number of popped words.
//
//   Parameters
//     DATA_W     word width
//     NUM_VC     number of virtual channels (2, 4 or 8)
//     VCSEL_LSB  LSB of the VC-select field in the word
//     STRICT     1: stall on any almost-full; 0: stall on destination only
//     HOL_LIMIT  blocked cycles before hol_blocked asserts (1..255)
//
//   Ports
//     clk    clock, all state on rising edge
//     reset  asynchronous active-high reset
//     bus    main_pop_arb_if.master (FIFO flags/data in, pop + demux out)
//
//   Optional feature
//     MAIN_POP_STATS_EN  when defined, pop_count counts pops (wraps at
//                        16 bits); otherwise pop_count is tied to 0.
// ----------------------------------------------------------------------------
module main_pop_arb #(
  parameter int DATA_W    = 6,
  parameter int NUM_VC    = 2,
  parameter int VCSEL_LSB = 4,
  parameter int STRICT    = 0,
  parameter int HOL_LIMIT = 8
) (
  input logic           clk,
  input logic           reset,
  main_pop_arb_if.master bus
);

  localparam int         SEL_W   = $clog2(NUM_VC);
  localparam logic [7:0] HOL_MAX = 8'(HOL_LIMIT);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    HOLD = 2'b10
  } state_t;

  logic [SEL_W-1:0] dest;
  logic             dest_af;
  logic             any_af;
  logic             go;
  logic [7:0]       hol_next;

  state_t            state_reg;
  logic [DATA_W-1:0] data_reg;
  logic              valid_reg;
  logic [7:0]        hol_reg;
  logic              hol_blocked_reg;

  assign dest    = bus.Main_data_out[VCSEL_LSB +: SEL_W];
  assign dest_af = bus.VC_almost_full[dest];
  assign any_af  = |bus.VC_almost_full;

  always_comb begin
    go = !bus.Main_empty && ((STRICT != 0) ? !any_af : !dest_af);
  end

  // The FIFO must never see a pop while the block is held in reset.
  assign bus.Main_rd = go && !reset;

  // Blocked means a word is waiting but cannot go; an empty FIFO or a
  // successful pop both restart the starvation count.
  always_comb begin
    hol_next = hol_reg;
    if (go || bus.Main_empty) begin
      hol_next = '0;
    end else if (hol_reg != HOL_MAX) begin
      hol_next = hol_reg + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg       <= IDLE;
      data_reg        <= '0;
      valid_reg       <= 1'b0;
      hol_reg         <= '0;
      hol_blocked_reg <= 1'b0;
    end else begin
      data_reg        <= go ? bus.Main_data_out : '0;
      valid_reg       <= go;
      hol_reg         <= hol_next;
      hol_blocked_reg <= (hol_next == HOL_MAX);
      // Empty wins over HOLD when both apply.
      if (bus.Main_empty) begin
        state_reg <= IDLE;
      end else if (go) begin
        state_reg <= RUN;
      end else begin
        state_reg <= HOLD;
      end
    end
  end

  assign bus.demux_vcid_in       = data_reg;
  assign bus.demux_vcid_valid_in = valid_reg;
  assign bus.pop_state           = state_reg;
  assign bus.hol_blocked         = hol_blocked_reg;

`ifdef MAIN_POP_STATS_EN
  logic [15:0] pop_count_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pop_count_reg <= '0;
    end else if (go) begin
      pop_count_reg <= pop_count_reg + 16'd1;
    end
  end

  assign bus.pop_count = pop_count_reg;
`else
  assign bus.pop_count = '0;
`endif

endmodule

// File: tb/tb_main_pop_arb.sv
// ----------------------------------------------------------------------------
// tb_main_pop_arb
//   Drives three arbiter configurations from one shared stimulus:
//     u0: defaults (NUM_VC=2, STRICT=0, HOL_LIMIT=8)
//     u1: NUM_VC=2, STRICT=1, HOL_LIMIT=8
//     u2: NUM_VC=4, STRICT=0, HOL_LIMIT=3
//   Expected values come from a rule-level model of each configuration,
//   a vector table of pop decisions, and hand-written corner sequences.
// ----------------------------------------------------------------------------
module tb_main_pop_arb;

  logic       clk;
  logic       reset;
  logic       empty;
  logic [5:0] data;
  logic [3:0] af;

  int compared   = 0;
  int mismatched = 0;

  // per-configuration parameters seen by the model
  int p_nvc    [3] = '{2, 2, 4};
  int p_strict [3] = '{0, 1, 0};
  int p_lim    [3] = '{8, 8, 3};

  main_pop_arb_if #(.DATA_W(6), .NUM_VC(2)) if0 ();
  main_pop_arb_if #(.DATA_W(6), .NUM_VC(2)) if1 ();
  main_pop_arb_if #(.DATA_W(6), .NUM_VC(4)) if2 ();

  assign if0.Main_empty     = empty;
  assign if0.Main_data_out  = data;
  assign if0.VC_almost_full = af[1:0];
  assign if1.Main_empty     = empty;
  assign if1.Main_data_out  = data;
  assign if1.VC_almost_full = af[1:0];
  assign if2.Main_empty     = empty;
  assign if2.Main_data_out  = data;
  assign if2.VC_almost_full = af;

  main_pop_arb #(.DATA_W(6), .NUM_VC(2), .VCSEL_LSB(4), .STRICT(0), .HOL_LIMIT(8))
    u0 (.clk(clk), .reset(reset), .bus(if0));
  main_pop_arb #(.DATA_W(6), .NUM_VC(2), .VCSEL_LSB(4), .STRICT(1), .HOL_LIMIT(8))
    u1 (.clk(clk), .reset(reset), .bus(if1));
  main_pop_arb #(.DATA_W(6), .NUM_VC(4), .VCSEL_LSB(4), .STRICT(0), .HOL_LIMIT(3))
    u2 (.clk(clk), .reset(reset), .bus(if2));

  logic [2:0]  rd;
  logic [5:0]  dout [3];
  logic [2:0]  vld;
  logic [1:0]  st   [3];
  logic [2:0]  hb;
  logic [15:0] pc   [3];

  assign rd[0] = if0.Main_rd;             assign rd[1] = if1.Main_rd;             assign rd[2] = if2.Main_rd;
  assign dout[0] = if0.demux_vcid_in;     assign dout[1] = if1.demux_vcid_in;     assign dout[2] = if2.demux_vcid_in;
  assign vld[0] = if0.demux_vcid_valid_in; assign vld[1] = if1.demux_vcid_valid_in; assign vld[2] = if2.demux_vcid_valid_in;
  assign st[0] = if0.pop_state;           assign st[1] = if1.pop_state;           assign st[2] = if2.pop_state;
  assign hb[0] = if0.hol_blocked;         assign hb[1] = if1.hol_blocked;         assign hb[2] = if2.hol_blocked;
  assign pc[0] = if0.pop_count;           assign pc[1] = if1.pop_count;           assign pc[2] = if2.pop_count;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  int m_data [3], m_valid [3], m_state [3], m_hol [3], m_cnt [3];

  localparam bit STATS_ON =
`ifdef MAIN_POP_STATS_EN
    1'b1;
`else
    1'b0;
`endif

  function automatic bit model_go(int k);
    int dest;
    int mask;
    if (empty) return 1'b0;
    dest = (int'(data) >> 4) % p_nvc[k];
    mask = int'(af) & ((1 << p_nvc[k]) - 1);
    if (p_strict[k] != 0) return (mask == 0);
    return (((mask >> dest) & 1) == 0);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_data[k] = 0; m_valid[k] = 0; m_state[k] = 0; m_hol[k] = 0; m_cnt[k] = 0;
    end
  endtask

  task automatic model_edge();
    bit g;
    for (int k = 0; k < 3; k++) begin
      g = model_go(k);
      m_data[k]  = g ? int'(data) : 0;
      m_valid[k] = g ? 1 : 0;
      m_state[k] = empty ? 0 : (g ? 1 : 2);
      if (g || empty) m_hol[k] = 0;
      else if (m_hol[k] < p_lim[k]) m_hol[k] = m_hol[k] + 1;
      if (g) m_cnt[k] = (m_cnt[k] + 1) & 16'hFFFF;
    end
  endtask

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_outs();
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("u%0d_data", k),  32'(dout[k]), 32'(m_data[k]));
      chk($sformatf("u%0d_valid", k), 32'(vld[k]),  32'(m_valid[k]));
      chk($sformatf("u%0d_state", k), 32'(st[k]),   32'(m_state[k]));
      chk($sformatf("u%0d_hol", k),   32'(hb[k]),   32'(m_hol[k] == p_lim[k]));
      chk($sformatf("u%0d_count", k), 32'(pc[k]),   STATS_ON ? 32'(m_cnt[k]) : 32'd0);
    end
  endtask

  task automatic check_rd_model(input string tag);
    for (int k = 0; k < 3; k++)
      chk($sformatf("%s_u%0d_rd", tag, k), 32'(rd[k]), 32'(model_go(k)));
  endtask

  task automatic set_in(input bit e, input logic [5:0] d, input logic [3:0] a);
    empty = e; data = d; af = a;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_outs();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit         e;
    logic [5:0] d;
    logic [3:0] a;
    logic [2:0] rd_exp;   // bit k = expected Main_rd of u<k>
  } vec_t;

  vec_t vecs [10];

  logic [5:0] stream [3];

  initial begin
    vecs[0] = '{1'b1, 6'h05, 4'b0000, 3'b000};
    vecs[1] = '{1'b0, 6'h05, 4'b0000, 3'b111};
    vecs[2] = '{1'b0, 6'h05, 4'b0010, 3'b101};
    vecs[3] = '{1'b0, 6'h15, 4'b0010, 3'b000};
    vecs[4] = '{1'b0, 6'h15, 4'b0001, 3'b101};
    vecs[5] = '{1'b0, 6'h30, 4'b1000, 3'b011};
    vecs[6] = '{1'b0, 6'h20, 4'b1000, 3'b111};
    vecs[7] = '{1'b1, 6'h15, 4'b0010, 3'b000};
    vecs[8] = '{1'b0, 6'h2A, 4'b0100, 3'b011};
    vecs[9] = '{1'b0, 6'h3F, 4'b0111, 3'b100};
    stream[0] = 6'h05; stream[1] = 6'h12; stream[2] = 6'h23;

    reset = 1'b1;
    set_in(1'b0, 6'h05, 4'b0000);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    // reset state, with a poppable head present
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rst_u%0d_rd", k), 32'(rd[k]), 32'd0);
    end
    check_outs();
    reset = 1'b0;
    set_in(1'b1, 6'h00, 4'b0000);
    tick();

    // three-word stream, back to back
    for (int i = 0; i < 3; i++) begin
      set_in(1'b0, stream[i], 4'b0000);
      #1;
      chk($sformatf("stream%0d_rd", i), 32'(rd[0]), 32'd1);
      tick();
      chk($sformatf("stream%0d_data", i), 32'(dout[0]), 32'(stream[i]));
      chk($sformatf("stream%0d_valid", i), 32'(vld[0]), 32'd1);
    end
    chk("stream_count", 32'(pc[0]), STATS_ON ? 32'd3 : 32'd0);
    set_in(1'b1, 6'h00, 4'b0000);
    tick();
    chk("stream_idle_valid", 32'(vld[0]), 32'd0);
    chk("stream_idle_state", 32'(st[0]), 32'd0);

    // head-of-line blocking on VC1
    for (int i = 1; i <= 10; i++) begin
      set_in(1'b0, 6'h15, 4'b0010);
      #1;
      chk($sformatf("hol%0d_rd", i), 32'(rd[0]), 32'd0);
      tick();
      chk($sformatf("hol%0d_state", i), 32'(st[0]), 32'd2);
      chk($sformatf("hol%0d_flag", i), 32'(hb[0]), (i >= 8) ? 32'd1 : 32'd0);
    end
    set_in(1'b0, 6'h15, 4'b0000);
    #1;
    chk("hol_release_rd", 32'(rd[0]), 32'd1);
    tick();
    chk("hol_release_flag", 32'(hb[0]), 32'd0);
    chk("hol_release_state", 32'(st[0]), 32'd1);
    chk("hol_release_data", 32'(dout[0]), 32'h15);

    // table of pop decisions
    for (int i = 0; i < 10; i++) begin
      set_in(vecs[i].e, vecs[i].d, vecs[i].a);
      #1;
      for (int k = 0; k < 3; k++)
        chk($sformatf("vec%0d_u%0d_rd", i, k), 32'(rd[k]), 32'(vecs[i].rd_exp[k]));
      tick();
    end

    // asynchronous reset in the middle of a stream
    set_in(1'b0, 6'h05, 4'b0000);
    tick();
    #3;
    reset = 1'b1;
    model_reset();
    #1;
    for (int k = 0; k < 3; k++)
      chk($sformatf("arst_u%0d_rd", k), 32'(rd[k]), 32'd0);
    check_outs();
    @(posedge clk);
    #1;
    check_outs();
    reset = 1'b0;
    set_in(1'b0, 6'h12, 4'b0000);
    #1;
    chk("arst_first_rd", 32'(rd[0]), 32'd1);
    tick();
    chk("arst_first_data", 32'(dout[0]), 32'h12);
    chk("arst_first_valid", 32'(vld[0]), 32'd1);

    // randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      set_in(($urandom_range(0, 3) == 0), 6'($urandom), 4'($urandom & $urandom));
      #1;
      check_rd_model("rand");
      tick();
    end

    // pop counter wrap
    do_reset();
    set_in(1'b0, 6'h05, 4'b0000);
    for (int n = 0; n < 16'hFFFE; n++) begin
      @(posedge clk);
      model_edge();
    end
    #1;
    chk("wrap_preload", 32'(pc[0]), STATS_ON ? 32'hFFFE : 32'd0);
    for (int n = 0; n < 3; n++) tick();
    chk("wrap_final", 32'(pc[0]), STATS_ON ? 32'h0001 : 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/main_pop_arb.md
MAIN_POP_ARB -- requirements
Module: main_pop_arb

Interface
REQ-001 Parameter DATA_W, default 6, width of the main FIFO word and of the demux output word.
REQ-002 Parameter NUM_VC, default 2, number of virtual channels; legal values 2, 4 or 8.
REQ-003 Parameter VCSEL_LSB, default 4, LSB of the VC-select field inside the data word; field width SEL_W = log2(NUM_VC); VCSEL_LSB+SEL_W <= DATA_W.
REQ-004 Parameter STRICT, default 0; 1 = stall on any VC almost-full (legacy gating), 0 = stall only on the head word's destination VC.
REQ-005 Parameter HOL_LIMIT, default 8, consecutive head-of-line blocked cycles before hol_blocked asserts; range 1..255.
REQ-006 clk  input  1  single clock, all state on rising edge.
REQ-007 reset  input  1  asynchronous, active-high reset.
REQ-008 Main_empty  input  1  main FIFO empty flag.
REQ-009 Main_data_out  input  DATA_W  main FIFO head word, show-ahead (valid whenever Main_empty=0).
REQ-010 VC_almost_full  input  NUM_VC  per-VC almost-full flags, bit i = VC i.
REQ-011 Main_rd  output  1  combinational pop strobe to main FIFO.
REQ-012 demux_vcid_in  output  DATA_W  registered word to demux.
REQ-013 demux_vcid_valid_in  output  1  registered valid for demux_vcid_in.
REQ-014 pop_state  output  2  registered state: 00 IDLE, 01 RUN, 10 HOLD.
REQ-015 hol_blocked  output  1  registered head-of-line starvation flag.
REQ-016 pop_count  output  16  registered count of popped words.

Function
REQ-017 dest = Main_data_out[VCSEL_LSB +: SEL_W].
REQ-018 go = !Main_empty && (STRICT ? no bit of VC_almost_full set : VC_almost_full[dest]==0).
REQ-019 Main_rd SHALL equal go, combinationally, same cycle; Main_rd SHALL be 0 while reset=1.
REQ-020 Latency 1: at each edge with go=1, demux_vcid_in <= Main_data_out and demux_vcid_valid_in <= 1; with go=0, demux_vcid_in <= 0 and demux_vcid_valid_in <= 0.
REQ-021 Back-to-back pops SHALL sustain one word per cycle while go stays 1; no bubble between words.
REQ-022 State at each edge: Main_empty=1 -> IDLE; go=1 -> RUN; else -> HOLD; any state reaches any other in one edge.
REQ-023 hol counter (8-bit): +1 per edge with HOLD condition, saturating at HOL_LIMIT; cleared to 0 on any edge with go=1 or Main_empty=1.
REQ-024 hol_blocked SHALL be 1 exactly when hol counter == HOL_LIMIT.
REQ-025 Almost-full change on a VC not equal to dest SHALL NOT affect go when STRICT=0.
REQ-026 Main_empty and almost-full asserting in the same cycle: go=0, next state IDLE (empty has priority over HOLD).
REQ-027 A word with dest whose flag deasserts in cycle t SHALL be popped in cycle t (Main_rd=1 same cycle).

Reset
REQ-028 reset=1 SHALL immediately, regardless of clk, force demux_vcid_in=0, demux_vcid_valid_in=0, pop_state=IDLE, hol counter=0, hol_blocked=0, pop_count=0, Main_rd=0.
REQ-029 Reset mid-transfer SHALL discard the in-flight output word; the FIFO head is not popped during reset; first pop possible on the first edge after reset deasserts.

Configuration
REQ-030 Macro MAIN_POP_STATS_EN defined: pop_count increments by 1 on each edge with go=1, wrapping 16'hFFFF -> 0.
REQ-031 MAIN_POP_STATS_EN undefined: pop_count SHALL be constant 0 and no counter register synthesised; all other behaviour identical.

Verification
REQ-032 Default params, FIFO holds 0x05,0x12,0x23, no almost-full -> Main_rd=1 three cycles, demux outputs 0x05,0x12,0x23 with valid=1 on the following three edges, pop_count=3 (stats on).
REQ-033 STRICT=0, head 0x15 (dest VC1), VC_almost_full=2'b10 -> Main_rd=0, state HOLD, hol_blocked=1 after 8 edges; deassert bit1 -> Main_rd=1 same cycle, hol_blocked=0 next edge.
REQ-034 STRICT=0, head 0x05 (dest VC0), VC_almost_full=2'b10 -> popped normally; same stimulus with STRICT=1 -> Main_rd=0, state HOLD.
REQ-035 NUM_VC=4, VCSEL_LSB=4, heads 0x30 and 0x20, VC_almost_full=4'b1000 -> 0x30 blocked, pop_state=HOLD, no pop of 0x20 behind it.
REQ-036 Reset asserted between clock edges during a stream -> all outputs 0 immediately; after release with FIFO non-empty, first valid word appears one edge after first go.
REQ-037 Stats on, preload pop_count to 0xFFFE via 0xFFFE pops, pop 3 more -> pop_count reads 0x0001.
